// File: rtl/uart_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_if
// Host-side word handshake into the UART transmit frame sequencer.
//   i_data       : word offered by the host (DATA_W bits)
//   i_data_valid : host offers i_data this cycle
//   o_ready      : sequencer can accept a word (high only while idle)
// Modports: master = host / TX buffer side, slave = uart_tx_ctrl side.
// -----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_data_valid;
  logic              o_ready;

  modport master (
    output i_data,
    output i_data_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_data_valid,
    output o_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Frame sequencer for the UART transmit path. Accepts a word over a
// valid/ready handshake, generates the per-bit baud tick and drives the serial
// line through start, data (LSB first), optional parity and stop bits.
//
// Ports:
//   i_clk   : system clock
//   i_rst   : asynchronous active-low reset
//   bus     : uart_tx_ctrl_if.slave (i_data, i_data_valid, o_ready)
//   o_tx    : serial line, idle high
//   o_busy  : frame in progress (always !o_ready)
//   o_done  : one-cycle pulse during the last cycle of the final stop bit
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even, or odd when PARITY_ODD=1).
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_tx_ctrl_if.slave        bus,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_tx_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                stop_q, stop_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                bit_end;
  logic                stop_last;
  logic                stop_last_d;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign bit_end   = (baud_q == BAUD_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_data_valid) begin
          state_d = START;
          shift_d = bus.i_data;
`ifdef UART_TX_PARITY_EN
          par_d   = (^bus.i_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        stop_d = stop_q;
        if (bit_end) begin
          if (stop_last) state_d = IDLE;
          else           stop_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Baud count restarts on every state change; inside DATA/STOP it wraps
    // on bit_end to time the next bit of the same state.
    if (state_d != state_q || state_q == IDLE || bit_end) baud_d = '0;
    else                                                   baud_d = baud_q + 1'b1;

    // Outputs are registered by decoding the next-state values, so each
    // output flop already holds the value for the cycle it belongs to.
    stop_last_d = (STOP_BITS == 1) || stop_d;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == STOP) && (baud_d == BAUD_LAST) && stop_last_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.o_ready = ready_q;
  assign o_busy      = ~ready_q;
  assign o_tx        = tx_q;
  assign o_done      = done_q;

endmodule
